// File: rtl/hazard_pkg.sv
// Shared types for the dual-issue hazard unit: state encoding, issue-slot
// payload and the per-slot readiness rule.
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SECOND  = 2'd1,
    BR_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic             branch;
    logic             format;
    logic [6:0]       opcode;
    logic [REG_W-1:0] rg;
    logic [15:0]      operand;
  } slot_t;

  // A slot may issue when all its sources are free and, if it writes, its dest is free.
  // Branches never write, so their dest pending bit is ignored.
  function automatic logic slot_ready(input logic en, input slot_t s,
                                      input logic pend_a, input logic pend_b,
                                      input logic pend_d);
    return en && !pend_a && (s.format || !pend_b) && (s.branch || !pend_d);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register pending-write scoreboard. Up to two issues set bits per cycle and
// each writeback port clears one. A set wins over a clear of the same register,
// and register 0 never becomes pending.
// Build option: HAZARD_BYPASS_EN makes a same-cycle writeback hide the pending
// bit on the read ports (forwarding); otherwise reads see only the stored bits.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int WB_PORTS = 2
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      set_en_i1,
  input  logic [REG_W-1:0]          set_reg_i1,
  input  logic                      set_en_i2,
  input  logic [REG_W-1:0]          set_reg_i2,
  input  logic [WB_PORTS-1:0]       wb_valid_i,
  input  logic [REG_W*WB_PORTS-1:0] wb_reg_i,
  input  logic [REG_W-1:0]          rd_a_i1,
  input  logic [REG_W-1:0]          rd_b_i1,
  input  logic [REG_W-1:0]          rd_d_i1,
  input  logic [REG_W-1:0]          rd_a_i2,
  input  logic [REG_W-1:0]          rd_b_i2,
  input  logic [REG_W-1:0]          rd_d_i2,
  output logic                      pend_a_o1,
  output logic                      pend_b_o1,
  output logic                      pend_d_o1,
  output logic                      pend_a_o2,
  output logic                      pend_b_o2,
  output logic                      pend_d_o2
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] clr_v, set_v, visible;

  // Decode writeback clears and issue sets into one-hot vectors.
  always_comb begin
    clr_v = '0;
    set_v = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p]) clr_v[wb_reg_i[p*REG_W +: REG_W]] = 1'b1;
    end
    if (set_en_i1) set_v[set_reg_i1] = 1'b1;
    if (set_en_i2) set_v[set_reg_i2] = 1'b1;
    pending_d    = (pending_q & ~clr_v) | set_v;
    pending_d[0] = 1'b0;
  end

`ifdef HAZARD_BYPASS_EN
  assign visible = pending_q & ~clr_v;
`else
  assign visible = pending_q;
`endif

  assign pend_a_o1 = visible[rd_a_i1];
  assign pend_b_o1 = visible[rd_b_i1];
  assign pend_d_o1 = visible[rd_d_i1];
  assign pend_a_o2 = visible[rd_a_i2];
  assign pend_b_o2 = visible[rd_b_i2];
  assign pend_d_o2 = visible[rd_d_i2];

  // Pending-bit storage.
  always_ff @(posedge clock_i) begin
    if (reset_i) pending_q <= '0;
    else         pending_q <= pending_d;
  end

endmodule

// File: rtl/dual_issue_hazard_unit.sv
// Dual-issue hazard unit: checks the parser's instruction pair against the
// scoreboard and each other, issues 0/1/2 per cycle and stalls the parser.
// Build option: HAZARD_BYPASS_EN (see hazard_scoreboard) forwards same-cycle writebacks.
//
//  state   | meaning
//  RUN     | evaluate the pair held by the parser
//  SECOND  | slot 1 already issued, waiting to issue slot 2
//  BR_WAIT | branch issued, no issue until branchResolved_i;
//          | if slot 2 of that pair is still held, resume in SECOND
module dual_issue_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int WB_PORTS = 2
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      flushBack_i,
  input  logic                      enable_i1,
  input  logic                      enable_i2,
  input  logic                      isBranch_i1,
  input  logic                      isBranch_i2,
  input  logic                      format_i1,
  input  logic                      format_i2,
  input  logic [6:0]                opcode_i1,
  input  logic [6:0]                opcode_i2,
  input  logic [4:0]                reg_i1,
  input  logic [4:0]                reg_i2,
  input  logic [15:0]               operand_i1,
  input  logic [15:0]               operand_i2,
  input  logic [WB_PORTS-1:0]       wbValid_i,
  input  logic [5*WB_PORTS-1:0]     wbReg_i,
  input  logic                      branchResolved_i,
  output logic                      stall_o,
  output logic                      issue_o1,
  output logic                      issue_o2,
  output logic                      isBranch_o1,
  output logic                      isBranch_o2,
  output logic                      format_o1,
  output logic                      format_o2,
  output logic [6:0]                opcode_o1,
  output logic [6:0]                opcode_o2,
  output logic [4:0]                reg_o1,
  output logic [4:0]                reg_o2,
  output logic [15:0]               operand_o1,
  output logic [15:0]               operand_o2
);

  state_e state_q, state_d;
  logic   held2_q, held2_d;
  logic   iss1, iss2;
  logic   issue1_q, issue2_q;
  slot_t  s1, s2, pay1_q, pay2_q;
  logic   pa1, pb1, pd1, pa2, pb2, pd2;
  logic   ready1, ready2, dep;

  assign s1 = '{branch: isBranch_i1, format: format_i1, opcode: opcode_i1, rg: reg_i1, operand: operand_i1};
  assign s2 = '{branch: isBranch_i2, format: format_i2, opcode: opcode_i2, rg: reg_i2, operand: operand_i2};

  // The reg field is both dest and src A, so the A and D reads use the same index.
  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .WB_PORTS(WB_PORTS)) u_sb (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .set_en_i1  (iss1 && !isBranch_i1),
    .set_reg_i1 (reg_i1),
    .set_en_i2  (iss2 && !isBranch_i2),
    .set_reg_i2 (reg_i2),
    .wb_valid_i (wbValid_i),
    .wb_reg_i   (wbReg_i),
    .rd_a_i1    (reg_i1),
    .rd_b_i1    (operand_i1[4:0]),
    .rd_d_i1    (reg_i1),
    .rd_a_i2    (reg_i2),
    .rd_b_i2    (operand_i2[4:0]),
    .rd_d_i2    (reg_i2),
    .pend_a_o1  (pa1),
    .pend_b_o1  (pb1),
    .pend_d_o1  (pd1),
    .pend_a_o2  (pa2),
    .pend_b_o2  (pb2),
    .pend_d_o2  (pd2)
  );

  assign ready1 = slot_ready(enable_i1, s1, pa1, pb1, pd1);
  assign ready2 = slot_ready(enable_i2, s2, pa2, pb2, pd2);

  // r0 is never written, so touching it creates no pair dependency.
  assign dep = isBranch_i1 ||
               ((reg_i1 != 5'd0) &&
                ((reg_i2 == reg_i1) || (!format_i2 && (operand_i2[4:0] == reg_i1))));

  // Issue decision, stall and next state.
  always_comb begin
    state_d = state_q;
    held2_d = held2_q;
    iss1    = 1'b0;
    iss2    = 1'b0;
    stall_o = 1'b0;
    if (flushBack_i) begin
      state_d = RUN;
      held2_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (enable_i1) begin
            if (ready1) begin
              iss1 = 1'b1;
              if (enable_i2 && ready2 && !dep) begin
                iss2    = 1'b1;
                state_d = isBranch_i2 ? BR_WAIT : RUN;
              end else if (enable_i2) begin
                stall_o = 1'b1;
                if (isBranch_i1) begin
                  state_d = BR_WAIT;
                  held2_d = 1'b1;
                end else begin
                  state_d = SECOND;
                end
              end else begin
                state_d = isBranch_i1 ? BR_WAIT : RUN;
              end
            end else begin
              stall_o = 1'b1;
            end
          end else if (enable_i2) begin
            if (ready2) begin
              iss2    = 1'b1;
              state_d = isBranch_i2 ? BR_WAIT : RUN;
            end else begin
              stall_o = 1'b1;
            end
          end
        end
        SECOND: begin
          if (!enable_i2) begin
            state_d = RUN;
          end else if (ready2) begin
            iss2    = 1'b1;
            state_d = isBranch_i2 ? BR_WAIT : RUN;
          end else begin
            stall_o = 1'b1;
          end
        end
        BR_WAIT: begin
          stall_o = enable_i1 || enable_i2;
          if (branchResolved_i) begin
            state_d = held2_q ? SECOND : RUN;
            held2_d = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, issue strobes and payload registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= RUN;
      held2_q  <= 1'b0;
      issue1_q <= 1'b0;
      issue2_q <= 1'b0;
      pay1_q   <= '0;
      pay2_q   <= '0;
    end else begin
      state_q  <= state_d;
      held2_q  <= held2_d;
      issue1_q <= iss1;
      issue2_q <= iss2;
      pay1_q   <= iss1 ? s1 : '0;
      pay2_q   <= iss2 ? s2 : '0;
    end
  end

  assign issue_o1    = issue1_q;
  assign issue_o2    = issue2_q;
  assign isBranch_o1 = pay1_q.branch;
  assign isBranch_o2 = pay2_q.branch;
  assign format_o1   = pay1_q.format;
  assign format_o2   = pay2_q.format;
  assign opcode_o1   = pay1_q.opcode;
  assign opcode_o2   = pay2_q.opcode;
  assign reg_o1      = pay1_q.rg;
  assign reg_o2      = pay2_q.rg;
  assign operand_o1  = pay1_q.operand;
  assign operand_o2  = pay2_q.operand;

endmodule

// File: tb/tb_dual_issue_hazard_unit.sv
// Scoreboard bench for dual_issue_hazard_unit: directed pairs push expected
// issue records; a monitor pops and compares whenever an issue strobe appears.
module tb_dual_issue_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, flush, en1, en2, resolved;
  logic [29:0] s1_v, s2_v;
  logic [1:0]  wbv;
  logic [9:0]  wbr;

  logic        stall, iss1, iss2, br1, br2, fm1, fm2;
  logic [6:0]  op1, op2;
  logic [4:0]  rg1, rg2;
  logic [15:0] opd1, opd2;

  int checks = 0;
  int errors = 0;
  logic [61:0] exp_q[$];

  always #5 clk = ~clk;

  dual_issue_hazard_unit dut (
    .clock_i(clk), .reset_i(rst), .flushBack_i(flush),
    .enable_i1(en1), .enable_i2(en2),
    .isBranch_i1(s1_v[29]), .isBranch_i2(s2_v[29]),
    .format_i1(s1_v[28]), .format_i2(s2_v[28]),
    .opcode_i1(s1_v[27:21]), .opcode_i2(s2_v[27:21]),
    .reg_i1(s1_v[20:16]), .reg_i2(s2_v[20:16]),
    .operand_i1(s1_v[15:0]), .operand_i2(s2_v[15:0]),
    .wbValid_i(wbv), .wbReg_i(wbr), .branchResolved_i(resolved),
    .stall_o(stall), .issue_o1(iss1), .issue_o2(iss2),
    .isBranch_o1(br1), .isBranch_o2(br2),
    .format_o1(fm1), .format_o2(fm2),
    .opcode_o1(op1), .opcode_o2(op2),
    .reg_o1(rg1), .reg_o2(rg2),
    .operand_o1(opd1), .operand_o2(opd2)
  );

  function automatic logic [29:0] mk(input logic br, input logic fmt, input logic [6:0] op,
                                     input logic [4:0] rg, input logic [15:0] opnd);
    return {br, fmt, op, rg, opnd};
  endfunction

  // Monitor: every issue strobe consumes one expected record.
  always @(posedge clk) begin
    logic [61:0] got, want;
    #1;
    if (iss1 || iss2) begin
      got = {iss1, iss2, br1, fm1, op1, rg1, opd1, br2, fm2, op2, rg2, opd2};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue got=%h", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL issue_record got=%h want=%h", got, want);
        end
      end
    end
  end

  // One decision cycle: drive inputs, check stall, queue the expected issue.
  task automatic cyc(input logic e1, input logic [29:0] a, input logic e2, input logic [29:0] b,
                     input logic [1:0] wv, input logic [9:0] wr, input logic res, input logic fl,
                     input logic x_stall, input logic x1, input logic x2, input string name);
    @(negedge clk);
    en1 = e1; s1_v = a; en2 = e2; s2_v = b;
    wbv = wv; wbr = wr; resolved = res; flush = fl;
    #2;
    checks++;
    if (stall !== x_stall) begin
      errors++;
      $display("FAIL %s stall got=%b want=%b", name, stall, x_stall);
    end
    if (x1 || x2) exp_q.push_back({x1, x2, (x1 ? a : 30'd0), (x2 ? b : 30'd0)});
  endtask

  task automatic idle(input logic [1:0] wv, input logic [9:0] wr, input string name);
    cyc(1'b0, 30'd0, 1'b0, 30'd0, wv, wr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, name);
  endtask

  localparam logic [29:0] ZS = 30'd0;

  initial begin
    logic [29:0] A1a, A1b, A2, A4b, B1, B2, C0, C1, C2, D1, D2, E1, E2;
    logic [29:0] F1, F2, F3, G1, G2, G3, H1;
    A1a = mk(0, 1, 7'd10, 5'd1, 16'h1234);  A1b = mk(0, 1, 7'd11, 5'd2, 16'h5678);
    A2  = mk(0, 0, 7'd12, 5'd4, 16'h0001);  A4b = mk(0, 0, 7'd13, 5'd6, 16'h0002);
    B1  = mk(0, 1, 7'd20, 5'd3, 16'hABCD);  B2  = mk(0, 0, 7'd21, 5'd8, 16'h0003);
    C0  = mk(0, 1, 7'd22, 5'd5, 16'h0F0F);  C1  = mk(0, 0, 7'd23, 5'd9, 16'h0005);
    C2  = mk(0, 1, 7'd24, 5'd10, 16'h00AA);
    D1  = mk(1, 1, 7'd30, 5'd11, 16'h0040); D2  = mk(0, 1, 7'd31, 5'd12, 16'h0041);
    E1  = mk(0, 1, 7'd40, 5'd7, 16'h0777);  E2  = mk(0, 0, 7'd41, 5'd13, 16'h0007);
    F1  = mk(0, 1, 7'd50, 5'd14, 16'h1414); F2  = mk(0, 0, 7'd51, 5'd15, 16'h000E);
    F3  = mk(0, 0, 7'd52, 5'd16, 16'h000E);
    G1  = mk(0, 1, 7'd60, 5'd0, 16'h0000);  G2  = mk(0, 0, 7'd61, 5'd18, 16'h0000);
    G3  = mk(0, 1, 7'd62, 5'd17, 16'h1717);
    H1  = mk(1, 1, 7'd70, 5'd0, 16'h0070);

    rst = 1'b1; flush = 1'b0; en1 = 1'b0; en2 = 1'b0; resolved = 1'b0;
    s1_v = '0; s2_v = '0; wbv = '0; wbr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++; if ({iss1, iss2} !== 2'b00) begin errors++; $display("FAIL reset_issue got=%b want=00", {iss1, iss2}); end
    checks++;
    if ({br1, fm1, op1, rg1, opd1, br2, fm2, op2, rg2, opd2} !== 60'd0) begin
      errors++;
      $display("FAIL reset_payload got=%h want=0", {br1, fm1, op1, rg1, opd1, br2, fm2, op2, rg2, opd2});
    end

    // Independent pair, then confirm r1/r2 were marked and cleared.
    cyc(1, A1a, 1, A1b, 2'b00, 10'd0, 0, 0, 0, 1, 1, "pair_indep");
    cyc(1, A2, 0, ZS, 2'b00, 10'd0, 0, 0, 1, 0, 0, "raw_r1_stall");
    idle(2'b11, {5'd2, 5'd1}, "wb_r1_r2");
    cyc(1, A2, 1, A4b, 2'b00, 10'd0, 0, 0, 0, 1, 1, "pair_after_wb");
    idle(2'b11, {5'd6, 5'd4}, "wb_r4_r6");

    // Intra-pair RAW on r3: slot 1 alone, slot 2 held in SECOND.
    cyc(1, B1, 1, B2, 2'b00, 10'd0, 0, 0, 1, 1, 0, "dep_issue1");
    cyc(1, B1, 1, B2, 2'b00, 10'd0, 0, 0, 1, 0, 0, "second_wait1");
    cyc(1, B1, 1, B2, 2'b00, 10'd0, 0, 0, 1, 0, 0, "second_wait2");
`ifdef HAZARD_BYPASS_EN
    cyc(1, B1, 1, B2, 2'b01, {5'd0, 5'd3}, 0, 0, 0, 0, 1, "second_wb_fwd");
`else
    cyc(1, B1, 1, B2, 2'b01, {5'd0, 5'd3}, 0, 0, 1, 0, 0, "second_wb");
    cyc(1, B1, 1, B2, 2'b00, 10'd0, 0, 0, 0, 0, 1, "second_issue");
`endif

    // r5 pending blocks the whole pair until written back.
    cyc(1, C0, 0, ZS, 2'b01, {5'd0, 5'd8}, 0, 0, 0, 1, 0, "set_r5");
    cyc(1, C1, 1, C2, 2'b00, 10'd0, 0, 0, 1, 0, 0, "raw_r5_a");
    cyc(1, C1, 1, C2, 2'b00, 10'd0, 0, 0, 1, 0, 0, "raw_r5_b");
`ifdef HAZARD_BYPASS_EN
    cyc(1, C1, 1, C2, 2'b10, {5'd5, 5'd0}, 0, 0, 0, 1, 1, "raw_r5_fwd");
`else
    cyc(1, C1, 1, C2, 2'b10, {5'd5, 5'd0}, 0, 0, 1, 0, 0, "raw_r5_wb");
    cyc(1, C1, 1, C2, 2'b00, 10'd0, 0, 0, 0, 1, 1, "raw_r5_issue");
`endif
    idle(2'b11, {5'd10, 5'd9}, "wb_r9_r10");

    // Branch in slot 1: three stalled cycles, then slot 2 issues.
    cyc(1, D1, 1, D2, 2'b00, 10'd0, 0, 0, 1, 1, 0, "branch_issue");
    cyc(1, D1, 1, D2, 2'b00, 10'd0, 0, 0, 1, 0, 0, "br_wait1");
    cyc(1, D1, 1, D2, 2'b00, 10'd0, 0, 0, 1, 0, 0, "br_wait2");
    cyc(1, D1, 1, D2, 2'b00, 10'd0, 1, 0, 1, 0, 0, "br_resolve");
    cyc(1, D1, 1, D2, 2'b00, 10'd0, 0, 0, 0, 0, 1, "after_branch");
    idle(2'b01, {5'd0, 5'd12}, "wb_r12");

    // Set beats clear on r7.
    cyc(1, E1, 0, ZS, 2'b01, {5'd0, 5'd7}, 0, 0, 0, 1, 0, "set_wins");
    cyc(1, E2, 0, ZS, 2'b00, 10'd0, 0, 0, 1, 0, 0, "r7_still_pending");
    idle(2'b01, {5'd0, 5'd7}, "wb_r7");
    cyc(1, E2, 0, ZS, 2'b00, 10'd0, 0, 0, 0, 1, 0, "r7_cleared");
    idle(2'b01, {5'd0, 5'd13}, "wb_r13");

    // Flush out of SECOND keeps r14 pending.
    cyc(1, F1, 1, F2, 2'b00, 10'd0, 0, 0, 1, 1, 0, "f_issue1");
    cyc(1, F1, 1, F2, 2'b00, 10'd0, 0, 0, 1, 0, 0, "f_second");
    cyc(1, F1, 1, F2, 2'b00, 10'd0, 0, 1, 0, 0, 0, "flush");
    cyc(1, F3, 0, ZS, 2'b00, 10'd0, 0, 0, 1, 0, 0, "flush_keeps_r14");
    idle(2'b01, {5'd0, 5'd14}, "wb_r14");
    cyc(1, F3, 0, ZS, 2'b00, 10'd0, 0, 0, 0, 1, 0, "r14_cleared");
    idle(2'b01, {5'd0, 5'd16}, "wb_r16");

    // r0 never pending; slot 2 alone.
    cyc(1, G1, 0, ZS, 2'b00, 10'd0, 0, 0, 0, 1, 0, "write_r0");
    cyc(1, G2, 0, ZS, 2'b00, 10'd0, 0, 0, 0, 1, 0, "r0_never_pending");
    cyc(0, ZS, 1, G3, 2'b00, 10'd0, 0, 0, 0, 0, 1, "slot2_only");
    idle(2'b11, {5'd17, 5'd18}, "wb_r17_r18");

    // Reset while in BR_WAIT returns to RUN.
    cyc(1, H1, 0, ZS, 2'b00, 10'd0, 0, 0, 0, 1, 0, "br_alone");
    cyc(1, A1a, 1, A1b, 2'b00, 10'd0, 0, 0, 1, 0, 0, "br_wait_hold");
    @(negedge clk);
    en1 = 1'b0; en2 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, A1a, 1, A1b, 2'b00, 10'd0, 0, 0, 0, 1, 1, "after_reset_pair");
    idle(2'b11, {5'd2, 5'd1}, "tail1");
    idle(2'b00, 10'd0, "tail2");
    idle(2'b00, 10'd0, "tail3");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_issues got=%0d left want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
